// File: rtl/cpu_core_mc.sv
// cpu_core_mc: multi-cycle fetch/decode/execute core sharing one synchronous RAM for code and data
module cpu_core_mc #(
    parameter int DW     = 16,
    parameter int AW     = 10,
    parameter int NREG   = 64,
    parameter int RST_PC = 0
) (
    input  logic          clka,
    input  logic          rst,
    input  logic          run,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          halted,
    output logic          illegal,
    output logic [AW-1:0] pc,
    input  logic [7:0]    dbg_sel,
    output logic [DW-1:0] dbg_data
);
    localparam int LW = NREG > 1 ? $clog2(NREG) : 1;
    typedef enum logic [2:0] {FETCH1, FETCH2, EXEC, LOAD, HALT} state_t;
    state_t state, state_nx;
    logic [7:0] op, r;
    logic [DW-1:0] regs [NREG];
    logic [AW-1:0] pc_nx;
    logic [LW-1:0] ri;
    logic [DW-1:0] rv, wr_val;
    logic r_ok, uses_r, wr_en, bad;
    assign ri = r[LW-1:0];
    assign rv = regs[ri];
    assign r_ok = {1'b0, r} < 9'(NREG);
    assign uses_r = op >= 8'h02 && op <= 8'h07;
    assign halted = state == HALT;
    assign dbg_data = regs[LW'(32'(dbg_sel) % NREG)];
    // In EXEC the second instruction word is consumed straight off mem_rdata
    always_comb begin
        state_nx = state;
        pc_nx = pc;
        mem_addr = '0;
        mem_re = 1'b0;
        mem_we = 1'b0;
        mem_wdata = '0;
        wr_en = 1'b0;
        wr_val = mem_rdata;
        bad = 1'b0;
        case (state)
            FETCH1: if (run) begin
                mem_addr = pc;
                mem_re = 1'b1;
                state_nx = FETCH2;
            end
            FETCH2: begin
                mem_addr = pc + AW'(1);
                mem_re = 1'b1;
                pc_nx = pc + AW'(2);
                state_nx = EXEC;
            end
            EXEC: begin
                state_nx = FETCH1;
                bad = uses_r && !r_ok;
                case (op)
                    8'h00: ;
                    8'h01: pc_nx = mem_rdata[AW-1:0];
                    8'h02: begin
                        mem_addr = mem_rdata[AW-1:0];
                        mem_re = 1'b1;
                        state_nx = LOAD;
                    end
                    8'h03: begin
                        mem_addr = mem_rdata[AW-1:0];
                        mem_we = r_ok;
                        mem_wdata = r_ok ? rv : '0;
                    end
                    8'h04: wr_en = r_ok;
                    8'h05: begin
                        wr_en = r_ok;
                        wr_val = rv + mem_rdata;
                    end
                    8'h06: begin
                        wr_en = r_ok;
                        wr_val = rv - mem_rdata;
                    end
                    8'h07: if (r_ok && rv != '0) begin
                        wr_en = 1'b1;
                        wr_val = rv - DW'(1);
                        pc_nx = mem_rdata[AW-1:0];
                    end
                    8'hFF: state_nx = HALT;
                    default: bad = 1'b1;
                endcase
            end
            LOAD: begin
                wr_en = r_ok;
                state_nx = FETCH1;
            end
            default: ;
        endcase
        // Strobes must fall the instant reset asserts, even with run held high
        if (!rst) begin
            mem_addr = '0;
            mem_re = 1'b0;
            mem_we = 1'b0;
            mem_wdata = '0;
        end
    end
    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            state <= FETCH1;
            pc <= AW'(RST_PC);
            op <= '0;
            r <= '0;
            illegal <= 1'b0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            state <= state_nx;
            pc <= pc_nx;
            if (state == FETCH2) begin
                op <= mem_rdata[DW-1 -: 8];
                r <= mem_rdata[7:0];
            end
            if (bad) illegal <= 1'b1;
            if (wr_en) regs[ri] <= wr_val;
        end
    end
endmodule

// File: tb/tb_cpu_core_mc.sv
// tb_cpu_core_mc: randomized and directed programs checked against an instruction-level model
module tb_cpu_core_mc;
    localparam int DW = 16;
    localparam int AW = 10;
    localparam int NREG = 64;
    logic clka = 1'b0;
    logic rst = 1'b0;
    logic run = 1'b0;
    logic [AW-1:0] mem_addr, pc;
    logic mem_re, mem_we, halted, illegal;
    logic [DW-1:0] mem_wdata, mem_rdata, dbg_data;
    logic [7:0] dbg_sel = '0;
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [DW-1:0] ram [1024];
    logic [DW-1:0] img [1024];
    logic [DW-1:0] mm [1024];
    logic [DW-1:0] mr [NREG];
    logic ld = 1'b0;
    typedef struct {int addr; int data; int cyc;} st_t;
    st_t st_q[$];
    int m_pc, m_cycles;
    logic m_ill;

    cpu_core_mc #(.DW(DW), .AW(AW), .NREG(NREG), .RST_PC(0)) dut (
        .clka(clka), .rst(rst), .run(run), .mem_addr(mem_addr), .mem_re(mem_re),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .halted(halted),
        .illegal(illegal), .pc(pc), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clka = ~clka;

    always @(posedge clka) begin
        cyc <= rst ? cyc + 1 : 0;
        if (ld) begin
            for (int i = 0; i < 1024; i++) ram[i] <= img[i];
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            if (mem_re) mem_rdata <= ram[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Store monitor: every DUT write is matched against the model's ordered store list
    always @(negedge clka) if (rst) begin
        chk("strobe_excl", 32'(mem_re & mem_we), 32'd0);
        if (mem_we) begin
            if (st_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL store_unexpected: got addr %0h data %0h, expected no store", mem_addr, mem_wdata);
            end else begin
                st_t s;
                s = st_q.pop_front();
                chk("store_addr", 32'(mem_addr), s.addr);
                chk("store_data", 32'(mem_wdata), s.data);
                chk("store_cycle", cyc + 1, s.cyc);
            end
        end
    end

    task automatic iss(input int base);
        int p, c, op, r, a;
        logic ok;
        logic [15:0] w0, w1;
        p = 0;
        c = base;
        m_ill = 1'b0;
        for (int i = 0; i < NREG; i++) mr[i] = '0;
        for (int i = 0; i < 1024; i++) mm[i] = img[i];
        st_q.delete();
        for (int n = 0; n < 2000; n++) begin
            w0 = mm[p];
            w1 = mm[(p + 1) % 1024];
            p = (p + 2) % 1024;
            op = int'(w0[15:8]);
            r = int'(w0[7:0]);
            ok = r < NREG;
            a = int'(w1) % 1024;
            c += 3;
            if (op >= 2 && op <= 7 && !ok) m_ill = 1'b1;
            if (op == 255) break;
            case (op)
                0: ;
                1: p = a;
                2: begin
                    c += 1;
                    if (ok) mr[r] = mm[a];
                end
                3: if (ok) begin
                    mm[a] = mr[r];
                    st_q.push_back('{a, int'(mr[r]), c});
                end
                4: if (ok) mr[r] = w1;
                5: if (ok) mr[r] = mr[r] + w1;
                6: if (ok) mr[r] = mr[r] - w1;
                7: if (ok && mr[r] != 0) begin
                    mr[r] = mr[r] - 16'd1;
                    p = a;
                end
                default: m_ill = 1'b1;
            endcase
        end
        m_pc = p;
        m_cycles = c;
    endtask

    task automatic clr_img();
        for (int i = 0; i < 1024; i++) img[i] = '0;
    endtask

    task automatic put(input int a, input logic [15:0] w0, input logic [15:0] w1);
        img[a] = w0;
        img[a + 1] = w1;
    endtask

    task automatic start_prog(input int base);
        rst = 1'b0;
        run = 1'b0;
        ld = 1'b1;
        @(posedge clka);
        #1 ld = 1'b0;
        iss(base);
        @(negedge clka);
        rst = 1'b1;
        repeat (base) begin
            @(posedge clka);
            #1;
            chk("stall_re", 32'(mem_re), 32'd0);
            chk("stall_pc", 32'(pc), 32'd0);
        end
        run = 1'b1;
    endtask

    task automatic finish_prog();
        int w, nbad;
        w = 0;
        nbad = 0;
        while (!halted && w < 5000) begin
            @(posedge clka);
            #1;
            w++;
        end
        chk("halt_cycle", cyc, m_cycles);
        chk("halted", 32'(halted), 32'd1);
        chk("final_pc", 32'(pc), m_pc);
        chk("illegal", 32'(illegal), 32'(m_ill));
        for (int i = 0; i < NREG; i++) begin
            dbg_sel = 8'(i + 64 * (i % 4));
            #1 chk($sformatf("reg%0d", i), 32'(dbg_data), 32'(mr[i]));
        end
        repeat (3) begin
            @(posedge clka);
            #1 chk("halt_quiet", 32'(mem_re | mem_we), 32'd0);
        end
        chk("store_q_empty", st_q.size(), 0);
        for (int i = 0; i < 1024; i++) if (ram[i] !== mm[i]) nbad++;
        chk("ram_image", nbad, 0);
    endtask

    task automatic gen_rand();
        int k, op, r;
        logic [15:0] imm;
        k = $urandom_range(4, 20);
        clr_img();
        for (int i = 'h200; i < 'h240; i++) img[i] = 16'($urandom);
        for (int i = 0; i < k; i++) begin
            r = $urandom_range(0, 71);
            imm = 16'($urandom);
            op = $urandom_range(0, 9);
            if (op == 8) op = $urandom_range(8, 254);
            if (op == 9) op = $urandom_range(4, 6);
            if (op == 2 || op == 3) imm = 16'('h200 + $urandom_range(0, 63));
            if (op == 1 || op == 7) imm = 16'(2 * $urandom_range(i + 1, k));
            if (op == 7) r = $urandom_range(0, 7);
            put(2 * i, {8'(op), 8'(r)}, imm);
        end
        img[2 * k] = 16'hFF00 | 16'($urandom_range(0, 255));
    endtask

    initial begin
        // Reset asserted mid-store: strobe and state drop without a clock edge
        clr_img();
        put(0, 16'h0401, 16'h1234);
        put(2, 16'h0301, 16'h0020);
        put(4, 16'hFF00, 16'h0000);
        start_prog(0);
        repeat (5) @(posedge clka);
        #1;
        chk("t1_we_before", 32'(mem_we), 32'd1);
        chk("t1_addr_before", 32'(mem_addr), 32'h20);
        dbg_sel = 8'd1;
        #1 chk("t1_r1_before", 32'(dbg_data), 32'h1234);
        #1 rst = 1'b0;
        #1;
        chk("t1_we_reset", 32'(mem_we), 32'd0);
        chk("t1_re_reset", 32'(mem_re), 32'd0);
        chk("t1_addr_reset", 32'(mem_addr), 32'd0);
        chk("t1_wdata_reset", 32'(mem_wdata), 32'd0);
        chk("t1_pc_reset", 32'(pc), 32'd0);
        chk("t1_r1_reset", 32'(dbg_data), 32'd0);
        chk("t1_flags_reset", 32'({halted, illegal}), 32'd0);
        @(posedge clka);
        #1 chk("t1_store_dropped", 32'(ram['h20]), 32'd0);
        st_q.delete();

        // Three-instruction add/store, then the same with a 4-cycle run stall
        for (int b = 0; b < 8; b += 4) begin
            clr_img();
            put(0, 16'h0401, 16'h1234);
            put(2, 16'h0501, 16'h0010);
            put(4, 16'h0301, 16'h0020);
            put(6, 16'hFF00, 16'h0000);
            start_prog(b);
            finish_prog();
            chk("t2_ram20", 32'(ram['h20]), 32'h1244);
        end

        // LOOPEQ onto itself with R1=3
        clr_img();
        put(0, 16'h0401, 16'h0003);
        put(2, 16'h0701, 16'h0002);
        put(4, 16'hFF00, 16'h0000);
        start_prog(0);
        finish_prog();

        // Underflow/overflow and jump to the last word with PC wrap
        clr_img();
        put(0, 16'h0602, 16'h0001);
        put(2, 16'h0502, 16'h0001);
        put(4, 16'h0100, 16'h03FF);
        img['h3FF] = 16'hFF00;
        start_prog(0);
        dbg_sel = 8'd2;
        repeat (3) @(posedge clka);
        #1 chk("t4_r2_ffff", 32'(dbg_data), 32'hFFFF);
        repeat (3) @(posedge clka);
        #1 chk("t4_r2_zero", 32'(dbg_data), 32'h0);
        repeat (3) @(posedge clka);
        #1 chk("t4_fetch_3ff", 32'({mem_re, mem_addr}), 32'h7FF);
        @(posedge clka);
        #1 chk("t4_fetch_000", 32'({mem_re, mem_addr}), 32'h400);
        finish_prog();

        // Bad opcode and out-of-range register index
        clr_img();
        put(0, 16'h0900, 16'h0000);
        put(2, 16'h0450, 16'h1111);
        put(4, 16'h0403, 16'h0007);
        put(6, 16'hFF00, 16'h0000);
        start_prog(0);
        repeat (2) @(posedge clka);
        #1 chk("t5_ill_before", 32'(illegal), 32'd0);
        @(posedge clka);
        #1 chk("t5_ill_after", 32'(illegal), 32'd1);
        finish_prog();

        // Load then HALT
        clr_img();
        put(0, 16'h0205, 16'h0030);
        put(2, 16'hFF00, 16'h0000);
        img['h30] = 16'hBEEF;
        start_prog(0);
        dbg_sel = 8'd5;
        repeat (3) @(posedge clka);
        #1 chk("t6_r5_before", 32'(dbg_data), 32'h0);
        @(posedge clka);
        #1 chk("t6_r5_loaded", 32'(dbg_data), 32'hBEEF);
        dbg_sel = 8'd69;
        #1 chk("t6_dbg_mod", 32'(dbg_data), 32'hBEEF);
        finish_prog();

        for (int n = 0; n < 30; n++) begin
            gen_rand();
            start_prog(0);
            finish_prog();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
